// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - RAW/branch hazard controller for a 4-stage pipeline
// Optional operand forwarding is enabled by defining FORWARDING_EN.
module pipeline_hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int STALL_CW = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dof_valid,
    input  logic [REG_AW-1:0]   dof_da,
    input  logic [REG_AW-1:0]   dof_aa,
    input  logic [REG_AW-1:0]   dof_ba,
    input  logic                dof_rw,
    input  logic [1:0]          dof_md,
    input  logic                dof_ma,
    input  logic                dof_mb,
    input  logic                ex_br_taken,
    output logic                stall,
    output logic                ex_bubble,
    output logic                flush,
    output logic [1:0]          fwd_a_sel,
    output logic [1:0]          fwd_b_sel,
    output logic [STALL_CW-1:0] stall_cnt
);

    logic                r_ex_v;
    logic [REG_AW-1:0]   r_ex_da;
    logic                r_ex_rw;
    logic                r_ex_ld;
    logic                r_wb_v;
    logic [REG_AW-1:0]   r_wb_da;
    logic                r_wb_rw;
    logic [STALL_CW-1:0] r_stall_cnt;

    logic w_a_used;
    logic w_b_used;
    logic w_a_ex;
    logic w_a_wb;
    logic w_b_ex;
    logic w_b_wb;
    logic w_raw;
    logic w_flush;
    logic w_stall;
    logic w_bubble;

    // R0 is hardwired, so a zero source address never creates a dependency
    assign w_a_used = dof_valid & ~dof_ma & (dof_aa != '0);
    assign w_b_used = dof_valid & ~dof_mb & (dof_ba != '0);

    assign w_a_ex = r_ex_v & r_ex_rw & (r_ex_da == dof_aa);
    assign w_a_wb = r_wb_v & r_wb_rw & (r_wb_da == dof_aa);
    assign w_b_ex = r_ex_v & r_ex_rw & (r_ex_da == dof_ba);
    assign w_b_wb = r_wb_v & r_wb_rw & (r_wb_da == dof_ba);

`ifdef FORWARDING_EN
    // Only a load in EX cannot be bypassed; its data arrives from WB one cycle later
    assign w_raw = (w_a_used & w_a_ex & r_ex_ld) | (w_b_used & w_b_ex & r_ex_ld);

    always_comb begin
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        if (w_a_used & w_a_ex & ~r_ex_ld)
            fwd_a_sel = 2'b01;
        else if (w_a_used & w_a_wb)
            fwd_a_sel = 2'b10;
        if (w_b_used & w_b_ex & ~r_ex_ld)
            fwd_b_sel = 2'b01;
        else if (w_b_used & w_b_wb)
            fwd_b_sel = 2'b10;
    end
`else
    logic w_unused_ld;
    assign w_unused_ld = r_ex_ld;
    assign w_raw = (w_a_used & (w_a_ex | w_a_wb)) | (w_b_used & (w_b_ex | w_b_wb));
    assign fwd_a_sel = 2'b00;
    assign fwd_b_sel = 2'b00;
`endif

    // A taken branch squashes DOF, so a stall on the squashed instruction is moot
    assign w_flush  = ex_br_taken & ~rst;
    assign w_stall  = w_raw & ~w_flush;
    assign w_bubble = w_flush | w_stall;

    assign flush     = w_flush;
    assign stall     = w_stall;
    assign ex_bubble = w_bubble;
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_v      <= 1'b0;
            r_ex_da     <= '0;
            r_ex_rw     <= 1'b0;
            r_ex_ld     <= 1'b0;
            r_wb_v      <= 1'b0;
            r_wb_da     <= '0;
            r_wb_rw     <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (w_bubble) begin
                r_ex_v  <= 1'b0;
                r_ex_da <= '0;
                r_ex_rw <= 1'b0;
                r_ex_ld <= 1'b0;
            end else begin
                r_ex_v  <= dof_valid;
                r_ex_da <= dof_da;
                r_ex_rw <= dof_rw;
                r_ex_ld <= (dof_md == 2'b01);
            end
            r_wb_v  <= r_ex_v;
            r_wb_da <= r_ex_da;
            r_wb_rw <= r_ex_rw;
            if (w_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - vector table, corner sequences and random model check
module tb_pipeline_hazard_ctrl;

    typedef struct {
        logic       v;
        logic [4:0] da;
        logic [4:0] aa;
        logic [4:0] ba;
        logic       rw;
        logic [1:0] md;
        logic       ma;
        logic       mb;
    } instr_t;

    typedef struct {
        instr_t     in;
        logic       br;
        logic       s;
        logic       b;
        logic       f;
        logic [1:0] fa;
        logic [1:0] fb;
        int         cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dof_valid = 1'b0;
    logic [4:0]  dof_da = '0, dof_aa = '0, dof_ba = '0;
    logic        dof_rw = 1'b0;
    logic [1:0]  dof_md = '0;
    logic        dof_ma = 1'b0, dof_mb = 1'b0;
    logic        ex_br_taken = 1'b0;
    logic        stall, ex_bubble, flush;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [15:0] stall_cnt;
    logic        s_stall, s_bubble, s_flush;
    logic [1:0]  s_fa, s_fb;
    logic [1:0]  s_cnt;

    int n_chk = 0;
    int n_fail = 0;

    instr_t pipe[$];
    int     m_cnt;
    logic   e_stall, e_bub, e_flush;
    logic [1:0] e_fa, e_fb;
    vec_t   tbl[$];

    pipeline_hazard_ctrl #(.REG_AW(5), .STALL_CW(16)) u_dut (
        .clk(clk), .rst(rst), .dof_valid(dof_valid), .dof_da(dof_da),
        .dof_aa(dof_aa), .dof_ba(dof_ba), .dof_rw(dof_rw), .dof_md(dof_md),
        .dof_ma(dof_ma), .dof_mb(dof_mb), .ex_br_taken(ex_br_taken),
        .stall(stall), .ex_bubble(ex_bubble), .flush(flush),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_cnt(stall_cnt)
    );

    pipeline_hazard_ctrl #(.REG_AW(5), .STALL_CW(2)) u_sat (
        .clk(clk), .rst(rst), .dof_valid(dof_valid), .dof_da(dof_da),
        .dof_aa(dof_aa), .dof_ba(dof_ba), .dof_rw(dof_rw), .dof_md(dof_md),
        .dof_ma(dof_ma), .dof_mb(dof_mb), .ex_br_taken(ex_br_taken),
        .stall(s_stall), .ex_bubble(s_bubble), .flush(s_flush),
        .fwd_a_sel(s_fa), .fwd_b_sel(s_fb), .stall_cnt(s_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic instr_t nop_i();
        instr_t n;
        n.v = 0; n.da = 0; n.aa = 0; n.ba = 0; n.rw = 0; n.md = 0; n.ma = 0; n.mb = 0;
        return n;
    endfunction

    function automatic instr_t mk_i(int v, int da, int aa, int ba, int rw, int md, int ma, int mb);
        instr_t n;
        n.v = v[0]; n.da = da[4:0]; n.aa = aa[4:0]; n.ba = ba[4:0];
        n.rw = rw[0]; n.md = md[1:0]; n.ma = ma[0]; n.mb = mb[0];
        return n;
    endfunction

    function automatic vec_t mkv(instr_t in, int br, int s, int b, int f, int fa, int fb, int cnt);
        vec_t x;
        x.in = in; x.br = br[0]; x.s = s[0]; x.b = b[0]; x.f = f[0];
        x.fa = fa[1:0]; x.fb = fb[1:0]; x.cnt = cnt;
        return x;
    endfunction

    function automatic instr_t rnd_i();
        instr_t n;
        n.v  = ($urandom_range(0, 7) != 0);
        n.da = 5'($urandom_range(0, 3));
        n.aa = 5'($urandom_range(0, 3));
        n.ba = 5'($urandom_range(0, 3));
        n.rw = ($urandom_range(0, 3) != 0);
        n.md = 2'($urandom_range(0, 3));
        n.ma = ($urandom_range(0, 5) == 0);
        n.mb = ($urandom_range(0, 5) == 0);
        return n;
    endfunction

    // Does an older instruction e hold a pending write to register r
    function automatic logic writes(instr_t e, logic [4:0] r);
        return e.v && e.rw && (e.da == r);
    endfunction

    function automatic logic [1:0] fwd_src(logic used, instr_t ex, instr_t wb, logic [4:0] r);
        if (!used) return 2'd0;
        if (writes(ex, r) && ex.md != 2'b01) return 2'd1;
        if (writes(wb, r)) return 2'd2;
        return 2'd0;
    endfunction

    task automatic predict(input instr_t d, input logic br, input logic r);
        instr_t ex, wb;
        logic ua, ub, raw;
        ex = pipe[0];
        wb = pipe[1];
        ua = d.v && !d.ma && (d.aa != 0);
        ub = d.v && !d.mb && (d.ba != 0);
`ifdef FORWARDING_EN
        raw  = (ua && writes(ex, d.aa) && ex.md == 2'b01) || (ub && writes(ex, d.ba) && ex.md == 2'b01);
        e_fa = fwd_src(ua, ex, wb, d.aa);
        e_fb = fwd_src(ub, ex, wb, d.ba);
`else
        raw  = (ua && (writes(ex, d.aa) || writes(wb, d.aa))) ||
               (ub && (writes(ex, d.ba) || writes(wb, d.ba)));
        e_fa = 2'd0;
        e_fb = 2'd0;
`endif
        e_flush = br && !r;
        e_stall = raw && !e_flush;
        e_bub   = e_flush || e_stall;
    endtask

    task automatic step(input instr_t d, input logic br, input logic r);
        @(negedge clk);
        dof_valid = d.v; dof_da = d.da; dof_aa = d.aa; dof_ba = d.ba;
        dof_rw = d.rw; dof_md = d.md; dof_ma = d.ma; dof_mb = d.mb;
        ex_br_taken = br;
        rst = r;
        if (r) begin
            pipe.delete();
            pipe.push_back(nop_i());
            pipe.push_back(nop_i());
            m_cnt = 0;
        end
        #2;
        predict(d, br, r);
        chk("stall", 32'(stall), 32'(e_stall));
        chk("ex_bubble", 32'(ex_bubble), 32'(e_bub));
        chk("flush", 32'(flush), 32'(e_flush));
        chk("fwd_a_sel", 32'(fwd_a_sel), 32'(e_fa));
        chk("fwd_b_sel", 32'(fwd_b_sel), 32'(e_fb));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        chk("sat_cnt", 32'(s_cnt), 32'((m_cnt > 3) ? 3 : m_cnt));
        if (!r) begin
            pipe.push_front(e_bub ? nop_i() : d);
            void'(pipe.pop_back());
            if (e_stall && m_cnt < 65535) m_cnt++;
        end
    endtask

    initial begin
        instr_t d;
        int k, prev, guard;

`ifdef FORWARDING_EN
        tbl.push_back(mkv(mk_i(1,3,1,2,1,0,0,0), 0, 0,0,0,0,0,0));
        tbl.push_back(mkv(mk_i(1,4,3,5,1,0,0,0), 0, 0,0,0,1,0,0));
        tbl.push_back(mkv(mk_i(1,2,7,0,1,1,0,1), 0, 0,0,0,0,0,0));
        tbl.push_back(mkv(mk_i(1,6,2,0,1,0,0,1), 0, 1,1,0,0,0,0));
        tbl.push_back(mkv(mk_i(1,6,2,0,1,0,0,1), 0, 0,0,0,2,0,1));
        tbl.push_back(mkv(mk_i(1,0,1,1,1,0,0,0), 0, 0,0,0,0,0,1));
        tbl.push_back(mkv(mk_i(1,5,0,0,1,0,0,0), 0, 0,0,0,0,0,1));
        tbl.push_back(mkv(mk_i(1,0,1,0,0,0,0,1), 0, 0,0,0,0,0,1));
        tbl.push_back(mkv(mk_i(1,1,5,5,1,0,0,0), 1, 0,1,1,2,2,1));
        tbl.push_back(mkv(mk_i(1,6,5,5,1,0,0,0), 0, 0,0,0,0,0,1));
`else
        tbl.push_back(mkv(mk_i(1,3,1,2,1,0,0,0), 0, 0,0,0,0,0,0));
        tbl.push_back(mkv(mk_i(1,4,3,5,1,0,0,0), 0, 1,1,0,0,0,0));
        tbl.push_back(mkv(mk_i(1,4,3,5,1,0,0,0), 0, 1,1,0,0,0,1));
        tbl.push_back(mkv(mk_i(1,4,3,5,1,0,0,0), 0, 0,0,0,0,0,2));
        tbl.push_back(mkv(mk_i(1,2,7,0,1,1,0,1), 0, 0,0,0,0,0,2));
        tbl.push_back(mkv(mk_i(1,6,2,0,1,0,0,1), 0, 1,1,0,0,0,2));
        tbl.push_back(mkv(mk_i(1,6,2,0,1,0,0,1), 0, 1,1,0,0,0,3));
        tbl.push_back(mkv(mk_i(1,6,2,0,1,0,0,1), 0, 0,0,0,0,0,4));
        tbl.push_back(mkv(mk_i(1,0,1,1,1,0,0,0), 0, 0,0,0,0,0,4));
        tbl.push_back(mkv(mk_i(1,5,0,0,1,0,0,0), 0, 0,0,0,0,0,4));
        tbl.push_back(mkv(mk_i(1,0,1,0,0,0,0,1), 0, 0,0,0,0,0,4));
        tbl.push_back(mkv(mk_i(1,1,5,5,1,0,0,0), 1, 0,1,1,0,0,4));
        tbl.push_back(mkv(mk_i(1,6,5,5,1,0,0,0), 0, 0,0,0,0,0,4));
`endif

        // Reset with random inputs must present all-zero outputs
        for (int i = 0; i < 3; i++) begin
            step(rnd_i(), 1'($urandom_range(0, 1)), 1'b1);
            chk("rst_stall", 32'(stall), 0);
            chk("rst_flush", 32'(flush), 0);
            chk("rst_bubble", 32'(ex_bubble), 0);
            chk("rst_cnt", 32'(stall_cnt), 0);
        end

        foreach (tbl[i]) begin
            step(tbl[i].in, tbl[i].br, 1'b0);
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(tbl[i].s));
            chk($sformatf("vec%0d_bubble", i), 32'(ex_bubble), 32'(tbl[i].b));
            chk($sformatf("vec%0d_flush", i), 32'(flush), 32'(tbl[i].f));
            chk($sformatf("vec%0d_fa", i), 32'(fwd_a_sel), 32'(tbl[i].fa));
            chk($sformatf("vec%0d_fb", i), 32'(fwd_b_sel), 32'(tbl[i].fb));
            chk($sformatf("vec%0d_cnt", i), 32'(stall_cnt), 32'(tbl[i].cnt));
        end

        // Chain of dependent loads until at least 5 stall cycles, then saturation
        step(nop_i(), 1'b0, 1'b1);
        k = 1; prev = 7; guard = 0;
        while (m_cnt < 5 && guard < 60) begin
            d = mk_i(1, k, prev, 0, 1, 1, 0, 1);
            step(d, 1'b0, 1'b0);
            if (!e_stall) begin
                prev = k;
                k = (k % 6) + 1;
            end
            guard++;
        end
        if (guard >= 60) begin
            n_chk++; n_fail++;
            $display("FAIL sat_seq_timeout: got %0d stalls expected at least 5", m_cnt);
        end
        step(nop_i(), 1'b0, 1'b0);
        chk("sat_hold3", 32'(s_cnt), 3);
        chk("cnt_ge5", 32'(stall_cnt >= 16'd5), 1);

        // Random traffic; DOF is held while stalled, occasional mid-stream reset
        step(nop_i(), 1'b0, 1'b1);
        d = rnd_i();
        for (int i = 0; i < 600; i++) begin
            logic r, br;
            r  = ($urandom_range(0, 59) == 0);
            br = ($urandom_range(0, 7) == 0);
            step(d, br, r);
            if (r || !e_stall) d = rnd_i();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
